// File: rtl/dcd_inst_queue_if.sv
// Decode-to-allocate handshake bundle for the decoded-instruction queue.
// The master side is decode plus the allocate consumer; the slave side is the queue.
interface dcd_inst_queue_if #(
    parameter int INST_W = 66,
    parameter int PTR_W  = 3
);
    logic [INST_W-1:0] dcd_inst_in;
    logic              bck_lp_in;
    logic              flush_in;
    logic              deq_in;
    logic [INST_W-1:0] inst_out;
    logic              bck_lp_out;
    logic              inst_valid_out;
    logic              stall_out;
    logic [PTR_W:0]    count_out;

    modport master (
        output dcd_inst_in, bck_lp_in, flush_in, deq_in,
        input  inst_out, bck_lp_out, inst_valid_out, stall_out, count_out
    );

    modport slave (
        input  dcd_inst_in, bck_lp_in, flush_in, deq_in,
        output inst_out, bck_lp_out, inst_valid_out, stall_out, count_out
    );
endinterface

// File: rtl/dcd_inst_queue.sv
// Decoded-instruction FIFO between decode and allocate/rename, with flush and back-pressure.
// Optional same-cycle empty-queue bypass is enabled by defining DCD_QUEUE_BYPASS_EN.
module dcd_inst_queue #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int INST_W = 66
) (
    input  logic             clk,
    input  logic             rst_n,
    dcd_inst_queue_if.slave  q_if
);
    localparam int             ENT_W    = INST_W + 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [PTR_W:0]              cnt_q, cnt_d;

    logic             in_vld, empty, full, byp, enq, deq;
    logic [ENT_W-1:0] head_ent;

    assign in_vld = q_if.dcd_inst_in[INST_W-1];
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL_CNT);

`ifdef DCD_QUEUE_BYPASS_EN
    // Empty queue with a consumer waiting: hand the word straight through, never stored.
    assign byp = empty & in_vld & q_if.deq_in & ~q_if.flush_in;
`else
    assign byp = 1'b0;
`endif

    // Full blocks enqueue even alongside a dequeue so stall stays registered-only.
    assign enq = in_vld & ~full & ~q_if.flush_in & ~byp;
    assign deq = q_if.deq_in & ~empty & ~q_if.flush_in;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (q_if.flush_in) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq) tail_d = tail_q + 1'b1;
            if (deq) head_d = head_q + 1'b1;
            case ({enq, deq})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry contents need no reset; occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= {q_if.bck_lp_in, q_if.dcd_inst_in};
    end

    assign head_ent = mem_q[head_q];

    always_comb begin
        q_if.inst_out   = '0;
        q_if.bck_lp_out = 1'b0;
        if (byp) begin
            q_if.inst_out   = q_if.dcd_inst_in;
            q_if.bck_lp_out = q_if.bck_lp_in;
        end else if (!empty) begin
            q_if.inst_out   = head_ent[INST_W-1:0];
            q_if.bck_lp_out = head_ent[INST_W];
        end
    end

    assign q_if.inst_valid_out = ~empty | byp;
    assign q_if.stall_out      = full;
    assign q_if.count_out      = cnt_q;

endmodule

// File: tb/tb_dcd_inst_queue.sv
// Scoreboard bench for dcd_inst_queue: stimulus pushes expected entries, a negedge monitor pops and checks.
module tb_dcd_inst_queue;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int INST_W = 66;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcd_inst_queue_if #(.INST_W(INST_W), .PTR_W(PTR_W)) qif();

    dcd_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .INST_W(INST_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (qif)
    );

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    logic [INST_W:0] exp_q[$];

    task automatic chk(input string name, input logic [INST_W:0] act, input logic [INST_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] mk(input logic [15:0] pc);
        logic [31:0] tag;
        tag = 32'hC0DE_0000 | {16'h0, pc};
        return {1'b1, 1'b0, tag, 16'h0000, pc};
    endfunction

    // Drive one cycle; model acceptance at the edge exactly as the queue rules define it.
    task automatic step(input logic [INST_W-1:0] inst, input logic bl, input logic fl, input logic dq);
        bit enq_ok, deq_ok;
        qif.dcd_inst_in = inst;
        qif.bck_lp_in   = bl;
        qif.flush_in    = fl;
        qif.deq_in      = dq;
        @(posedge clk);
        enq_ok = inst[INST_W-1] && (m_cnt < DEPTH);
        deq_ok = dq && (m_cnt > 0);
        if (fl) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (enq_ok) exp_q.push_back({bl, inst});
            m_cnt = m_cnt + (enq_ok ? 1 : 0) - (deq_ok ? 1 : 0);
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [INST_W:0] e;
        chk("count", {{(INST_W-PTR_W){1'b0}}, qif.count_out}, (INST_W+1)'(m_cnt));
        chk("valid", {{INST_W{1'b0}}, qif.inst_valid_out}, (INST_W+1)'(m_cnt != 0));
        chk("stall", {{INST_W{1'b0}}, qif.stall_out}, (INST_W+1)'(m_cnt == DEPTH));
        if (m_cnt == 0)
            chk("empty_out", {qif.bck_lp_out, qif.inst_out}, '0);
        if (rst_n && qif.deq_in && qif.inst_valid_out && !qif.flush_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underrun: head %h presented with no entry expected", qif.inst_out);
            end else begin
                e = exp_q.pop_front();
                chk("head", {qif.bck_lp_out, qif.inst_out}, e);
            end
        end
    end

    initial begin
        qif.dcd_inst_in = '0;
        qif.bck_lp_in   = 1'b0;
        qif.flush_in    = 1'b0;
        qif.deq_in      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        repeat (5) step('0, 1'b0, 1'b0, 1'b0);

        // Single pass, then bubble with junk payload and empty dequeue are ignored
        step(mk(16'h0040), 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step({1'b0, 65'h1_FFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);

        // Fill past full; ninth is dropped, then drain in order
        for (int i = 0; i < 9; i++) step(mk(16'(i)), i[0], 1'b0, 1'b0);
        step(mk(16'h00AA), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0, 1'b1);

        // Concurrent enqueue/dequeue across pointer wrap
        for (int i = 0; i < 6; i++) step(mk(16'h0100 + 16'(i)), i[1], 1'b0, 1'b0);
        for (int i = 6; i < 16; i++) step(mk(16'h0100 + 16'(i)), i[1], 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0, 1'b1);

        // Flush wins over same-cycle enqueue and dequeue
        for (int i = 0; i < 4; i++) step(mk(16'h0200 + 16'(i)), 1'b1, 1'b0, 1'b0);
        step(mk(16'h0299), 1'b1, 1'b1, 1'b1);
        repeat (3) step('0, 1'b0, 1'b0, 1'b1);

        // Async reset between edges with five entries held
        for (int i = 0; i < 5; i++) step(mk(16'h0300 + 16'(i)), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("rst_count", {{(INST_W-PTR_W){1'b0}}, qif.count_out}, '0);
        chk("rst_valid", {{INST_W{1'b0}}, qif.inst_valid_out}, '0);
        chk("rst_stall", {{INST_W{1'b0}}, qif.stall_out}, '0);
        chk("rst_head", {qif.bck_lp_out, qif.inst_out}, '0);
        m_cnt = 0;
        exp_q.delete();
        #1 rst_n = 1'b1;
        step(mk(16'h0400), 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        repeat (2) step('0, 1'b0, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
